quad_multi: RTL and testbench

Multi-channel quadrature decoder/counter for the pluto_servo firmware. It generalises the single-channel x4 quadrature counter with:
- parametrised channel count, counter width, synchroniser depth and index glitch-filter depth;
- an explicit arm/latch index handshake with a valid flag;
- an optional clear-on-index mode;
- sticky illegal-transition error detection.

It sits between the encoder input pins and the host register/readback mux.

---
 rtl/quad_multi_if.sv | 28 ++
 rtl/quad_multi.sv | 106 ++++++++++
 tb/tb_quad_multi.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/quad_multi_if.sv
// Encoder pin and host-side register bundle for the multi-channel quadrature counter.
// The host/pin side uses the master view; the decoder core uses the slave view.
interface quad_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16
);
  logic [CHANNELS-1:0]       A;
  logic [CHANNELS-1:0]       B;
  logic [CHANNELS-1:0]       Z;
  logic [CHANNELS-1:0]       index_arm;
  logic [CHANNELS-1:0]       index_mode;
  logic [CHANNELS-1:0]       count_clr;
  logic [CHANNELS-1:0]       error_clr;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS*WIDTH-1:0] index_pos;
  logic [CHANNELS-1:0]       index_valid;
  logic [CHANNELS-1:0]       error;

  modport master (
    output A, B, Z, index_arm, index_mode, count_clr, error_clr,
    input  count, index_pos, index_valid, error
  );

  modport slave (
    input  A, B, Z, index_arm, index_mode, count_clr, error_clr,
    output count, index_pos, index_valid, error
  );
endinterface

// File: rtl/quad_multi.sv
// Multi-channel x4 quadrature decoder with filtered index latch, clear-on-index
// and sticky illegal-transition detection; channels are fully independent.
module quad_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int SYNC     = 2,
  parameter int FILTER   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  quad_multi_if.slave  bus
);
  localparam int L = SYNC + FILTER - 1;

  logic [CHANNELS-1:0][WIDTH-1:0] count_all;
  logic [CHANNELS-1:0][WIDTH-1:0] pos_all;
  logic [CHANNELS-1:0]            valid_all;
  logic [CHANNELS-1:0]            err_all;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [SYNC:0]      a_sh_q, b_sh_q;
    logic [L-1:0]       z_sh_q;
    logic               stable_q, stable_d;
    logic               armed_q, armed_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   pos_q, pos_d;
    logic [WIDTH-1:0]   base;
    logic [FILTER-1:0]  win;
    logic               a, a_p, b, b_p;
    logic               step, illegal, dir, evt, latch;

    always_comb begin
      // Top SYNC-1 bit is the synchronised sample, the extra flop above it is the previous one
      a       = a_sh_q[SYNC-1];
      a_p     = a_sh_q[SYNC];
      b       = b_sh_q[SYNC-1];
      b_p     = b_sh_q[SYNC];
      step    = (a ^ a_p) ^ (b ^ b_p);
      illegal = (a ^ a_p) & (b ^ b_p);
      dir     = a ^ b_p;

      win      = z_sh_q[L-1 -: FILTER];
      stable_d = stable_q;
      if (&win)       stable_d = 1'b1;
      else if (~|win) stable_d = 1'b0;
      evt   = stable_d & ~stable_q;
      latch = evt & (armed_q | bus.index_arm[c]);

      // base is the count ignoring clear-on-index; it is also what the index latch captures
      base = count_q;
      if (bus.count_clr[c])  base = '0;
      else if (step)         base = dir ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      count_d = (latch && bus.index_mode[c]) ? '0 : base;

      pos_d   = pos_q;
      armed_d = armed_q;
      valid_d = valid_q;
      if (latch) begin
        pos_d   = base;
        valid_d = 1'b1;
        armed_d = 1'b0;
      end else if (bus.index_arm[c]) begin
        armed_d = 1'b1;
        valid_d = 1'b0;
      end

      err_d = illegal | (err_q & ~bus.error_clr[c]);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_sh_q   <= '0;
        b_sh_q   <= '0;
        z_sh_q   <= '0;
        stable_q <= 1'b0;
        armed_q  <= 1'b0;
        valid_q  <= 1'b0;
        err_q    <= 1'b0;
        count_q  <= '0;
        pos_q    <= '0;
      end else begin
        a_sh_q   <= {a_sh_q[SYNC-1:0], bus.A[c]};
        b_sh_q   <= {b_sh_q[SYNC-1:0], bus.B[c]};
        z_sh_q   <= {z_sh_q[L-2:0], bus.Z[c]};
        stable_q <= stable_d;
        armed_q  <= armed_d;
        valid_q  <= valid_d;
        err_q    <= err_d;
        count_q  <= count_d;
        pos_q    <= pos_d;
      end
    end

    assign count_all[c] = count_q;
    assign pos_all[c]   = pos_q;
    assign valid_all[c] = valid_q;
    assign err_all[c]   = err_q;
  end

  assign bus.count       = count_all;
  assign bus.index_pos   = pos_all;
  assign bus.index_valid = valid_all;
  assign bus.error       = err_all;
endmodule

// File: tb/tb_quad_multi.sv
// Testbench for quad_multi: directed scenarios plus random encoder traffic,
// compared every cycle against a phase-position / run-length reference model.
module tb_quad_multi;
  localparam int CH = 4, W = 16, SY = 2, FL = 4, CW = CH * W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  quad_multi_if #(.CHANNELS(CH), .WIDTH(W)) bus ();
  quad_multi #(.CHANNELS(CH), .WIDTH(W), .SYNC(SY), .FILTER(FL)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vectors = 0, miscompares = 0;

  // Reference model state
  logic [W-1:0]  m_count [CH];
  logic [W-1:0]  m_pos   [CH];
  bit            m_valid [CH];
  bit            m_err   [CH];
  bit            m_armed [CH];
  bit            m_stable[CH];
  int            run_hi  [CH];
  int            run_lo  [CH];
  logic [CH-1:0] hA[$], hB[$], hZ[$];
  int            ph_cur  [CH];

  // Gray position of an (A,B) pair along the forward sequence 00,10,11,01
  function automatic int ph(input bit a, input bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hA.delete(); hB.delete(); hZ.delete();
    for (int i = 0; i < SY + 2; i++) begin
      hA.push_back('0); hB.push_back('0); hZ.push_back('0);
    end
    for (int c = 0; c < CH; c++) begin
      m_count[c] = '0; m_pos[c] = '0; m_valid[c] = 0; m_err[c] = 0;
      m_armed[c] = 0; m_stable[c] = 0; run_hi[c] = 0; run_lo[c] = 0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    hA.push_front(bus.A); hB.push_front(bus.B); hZ.push_front(bus.Z);
    hA.delete(SY + 2); hB.delete(SY + 2); hZ.delete(SY + 2);
    for (int c = 0; c < CH; c++) begin
      int d;
      bit zd, ns, evt, aeff;
      logic [W-1:0] base;
      // Samples taken SY and SY+1 edges ago are what the decoder sees now
      d = (ph(hA[SY][c], hB[SY][c]) - ph(hA[SY+1][c], hB[SY+1][c]) + 4) % 4;
      zd = hZ[SY][c];
      if (zd) begin run_hi[c]++; run_lo[c] = 0; end
      else    begin run_lo[c]++; run_hi[c] = 0; end
      ns = m_stable[c];
      if (run_hi[c] >= FL) ns = 1;
      else if (run_lo[c] >= FL) ns = 0;
      evt = ns && !m_stable[c];
      m_stable[c] = ns;
      aeff = m_armed[c] || bus.index_arm[c];
      if (bus.count_clr[c]) base = '0;
      else if (d == 1)      base = m_count[c] + 1'b1;
      else if (d == 3)      base = m_count[c] - 1'b1;
      else                  base = m_count[c];
      m_count[c] = (evt && aeff && bus.index_mode[c]) ? '0 : base;
      if (evt && aeff) begin
        m_pos[c] = base; m_valid[c] = 1; m_armed[c] = 0;
      end else if (bus.index_arm[c]) begin
        m_armed[c] = 1; m_valid[c] = 0;
      end
      if (d == 2) m_err[c] = 1;
      else if (bus.error_clr[c]) m_err[c] = 0;
    end
  endtask

  task automatic tick();
    logic [CW-1:0] ec, ep;
    logic [CH-1:0] ev, ee;
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < CH; c++) begin
      ec[c*W +: W] = m_count[c];
      ep[c*W +: W] = m_pos[c];
      ev[c] = m_valid[c];
      ee[c] = m_err[c];
    end
    chk("count", bus.count, ec);
    chk("index_pos", bus.index_pos, ep);
    chk("index_valid", CW'(bus.index_valid), CW'(ev));
    chk("error", CW'(bus.error), CW'(ee));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_ph(input int c, input int p);
    ph_cur[c] = p & 3;
    case (ph_cur[c])
      0:       begin bus.A[c] = 1'b0; bus.B[c] = 1'b0; end
      1:       begin bus.A[c] = 1'b1; bus.B[c] = 1'b0; end
      2:       begin bus.A[c] = 1'b1; bus.B[c] = 1'b1; end
      default: begin bus.A[c] = 1'b0; bus.B[c] = 1'b1; end
    endcase
  endtask

  function automatic logic [W-1:0] cnt(input int c);
    return bus.count[c*W +: W];
  endfunction

  function automatic logic [W-1:0] pos(input int c);
    return bus.index_pos[c*W +: W];
  endfunction

  initial begin
    bus.A = '0; bus.B = '0; bus.Z = '0;
    bus.index_arm = '0; bus.index_mode = '0; bus.count_clr = '0; bus.error_clr = '0;
    for (int c = 0; c < CH; c++) ph_cur[c] = 0;
    model_reset();

    // Reset state
    ticks(2);
    chk("reset_count", bus.count, CW'(0));
    chk("reset_valid", CW'(bus.index_valid), CW'(0));
    rst_n = 1'b1;
    ticks(2);

    // Forward ch0: update lands exactly 3 edges after the change
    for (int i = 1; i <= 4; i++) begin
      set_ph(0, ph_cur[0] + 1);
      ticks(2);
      chk("fwd_early", CW'(cnt(0)), CW'(i - 1));
      tick();
      chk("fwd_at3", CW'(cnt(0)), CW'(i));
      ticks(5);
    end

    // Reverse ch1 from zero wraps to all-ones
    set_ph(1, ph_cur[1] - 1); ticks(4);
    chk("rev_wrap", CW'(cnt(1)), CW'(16'hFFFF));
    set_ph(1, ph_cur[1] - 1); ticks(4);
    set_ph(1, ph_cur[1] - 1); ticks(4);
    chk("rev_3", CW'(cnt(1)), CW'(16'hFFFD));
    chk("rev_noerr", CW'(bus.error[1]), CW'(0));

    // Illegal transition on ch2
    set_ph(2, ph_cur[2] + 2); ticks(2);
    chk("err_early", CW'(bus.error[2]), CW'(0));
    tick();
    chk("err_set", CW'(bus.error[2]), CW'(1));
    chk("err_cnt", CW'(cnt(2)), CW'(0));
    ticks(2);
    bus.error_clr[2] = 1'b1; tick(); bus.error_clr[2] = 1'b0;
    chk("err_clr", CW'(bus.error[2]), CW'(0));
    set_ph(2, ph_cur[2] + 2); ticks(2);
    bus.error_clr[2] = 1'b1; tick(); bus.error_clr[2] = 1'b0;
    chk("err_set_wins", CW'(bus.error[2]), CW'(1));

    // Index latch on ch0 at count 5
    set_ph(0, ph_cur[0] + 1); ticks(8);
    chk("cnt5", CW'(cnt(0)), CW'(5));
    bus.index_arm[0] = 1'b1; tick(); bus.index_arm[0] = 1'b0;
    bus.Z[0] = 1'b1; ticks(3); bus.Z[0] = 1'b0; ticks(10);
    chk("short_z", CW'(bus.index_valid[0]), CW'(0));
    bus.Z[0] = 1'b1; ticks(5);
    chk("idx_early", CW'(bus.index_valid[0]), CW'(0));
    tick();
    chk("idx_valid", CW'(bus.index_valid[0]), CW'(1));
    chk("idx_pos", CW'(pos(0)), CW'(5));
    ticks(4); bus.Z[0] = 1'b0; ticks(10);
    set_ph(0, ph_cur[0] + 1); ticks(4);
    bus.Z[0] = 1'b1; ticks(10); bus.Z[0] = 1'b0; ticks(10);
    chk("idx_noarm", CW'(pos(0)), CW'(5));

    // Clear-on-index on ch3, coincident with a +1 step
    bus.index_mode[3] = 1'b1;
    for (int i = 0; i < 100; i++) begin set_ph(3, ph_cur[3] + 1); tick(); end
    ticks(5);
    chk("cnt100", CW'(cnt(3)), CW'(100));
    bus.index_arm[3] = 1'b1; tick(); bus.index_arm[3] = 1'b0;
    bus.Z[3] = 1'b1; ticks(3);
    set_ph(3, ph_cur[3] + 1); ticks(3);
    chk("coi_pos", CW'(pos(3)), CW'(101));
    chk("coi_cnt", CW'(cnt(3)), CW'(0));
    bus.Z[3] = 1'b0; ticks(10);
    bus.index_arm[3] = 1'b1; tick(); bus.index_arm[3] = 1'b0;
    bus.Z[3] = 1'b1; ticks(3);
    set_ph(3, ph_cur[3] + 1); ticks(2);
    bus.count_clr[3] = 1'b1; tick(); bus.count_clr[3] = 1'b0;
    chk("coi_clr_pos", CW'(pos(3)), CW'(0));
    chk("coi_clr_cnt", CW'(cnt(3)), CW'(0));
    bus.Z[3] = 1'b0; ticks(10);

    // Random traffic on all channels
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 0) bus.index_mode = CH'($urandom);
      for (int c = 0; c < CH; c++) begin
        int r;
        r = $urandom_range(31);
        if (r < 6)       set_ph(c, ph_cur[c] + 1);
        else if (r < 12) set_ph(c, ph_cur[c] - 1);
        else if (r == 12) set_ph(c, ph_cur[c] + 2);
        if ($urandom_range(7) == 0) bus.Z[c] = ~bus.Z[c];
        bus.index_arm[c] = ($urandom_range(15) == 0);
        bus.count_clr[c] = ($urandom_range(63) == 0);
        bus.error_clr[c] = ($urandom_range(15) == 0);
      end
      tick();
    end
    bus.index_arm = '0; bus.count_clr = '0; bus.error_clr = '0; bus.Z = '0;
    bus.index_mode = '0;
    ticks(10);

    // Mid-operation reset on ch0 at 0x1234, armed, error set
    bus.count_clr[0] = 1'b1; tick(); bus.count_clr[0] = 1'b0;
    for (int i = 0; i < 16'h1234; i++) begin set_ph(0, ph_cur[0] + 1); tick(); end
    ticks(5);
    chk("cnt1234", CW'(cnt(0)), CW'(16'h1234));
    bus.index_arm[0] = 1'b1; tick(); bus.index_arm[0] = 1'b0;
    set_ph(0, ph_cur[0] + 2); ticks(4);
    chk("pre_rst_err", CW'(bus.error[0]), CW'(1));
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rst_count", bus.count, CW'(0));
    chk("rst_pos", bus.index_pos, CW'(0));
    chk("rst_valid", CW'(bus.index_valid), CW'(0));
    chk("rst_error", CW'(bus.error), CW'(0));
    bus.Z[0] = 1'b1; ticks(12);
    chk("rst_disarm", CW'(bus.index_valid[0]), CW'(0));
    bus.Z[0] = 1'b0; ticks(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
